// File: rtl/elevator_pkg.sv
// Shared elevator types: floor width, controller states and direction encoding.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic dir_toward(floor_t target, floor_t here);
        return (target > here) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/floor_call_queue_if.sv
// Call-write, floor-sensor and cabin-command signals of the floor call queue.
interface floor_call_queue_if;
    import elevator_pkg::*;

    logic   wr_valid;
    floor_t nextMemoryFloor;
    logic   BeginEndMemory_Flag;
    floor_t actualFloor;
    floor_t pos0Mem;
    logic   down_up_Flag;
    logic   motorUp;
    logic   motorDown;
    logic   doorOpen;
    logic   queueEmpty;
    logic   queueFull;
    logic   callDropped;

    modport master (
        output wr_valid, nextMemoryFloor, BeginEndMemory_Flag, actualFloor,
        input  pos0Mem, down_up_Flag, motorUp, motorDown, doorOpen,
               queueEmpty, queueFull, callDropped
    );

    modport slave (
        input  wr_valid, nextMemoryFloor, BeginEndMemory_Flag, actualFloor,
        output pos0Mem, down_up_Flag, motorUp, motorDown, doorOpen,
               queueEmpty, queueFull, callDropped
    );

endinterface

// File: rtl/door_timer.sv
// Door dwell counter: start loads DWELL_CYCLES, done marks the last open cycle.
module door_timer #(
    parameter int DWELL_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 8'(DWELL_CYCLES);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/floor_call_queue.sv
// Elevator call queue (circular buffer) driving an IDLE/MOVE/DOOR cabin controller.
// Define FLOOR_DEDUP_EN to discard writes whose floor is already queued.
module floor_call_queue
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int DEPTH        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    floor_call_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    floor_t             mem_q [DEPTH];
    floor_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    floor_t             pos0_q, pos0_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               drop_q, drop_d;
    state_e             state_q, state_d;
    logic               dir_q, dir_d;

    logic               pop;
    logic               wr_ok;
    logic               dup_hit;
    logic               timer_start;
    logic               timer_done;
    logic               motor_up, motor_down, door_open;

`ifdef FLOOR_DEDUP_EN
    logic [DEPTH-1:0] match;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dup
        logic [PTR_W-1:0] slot;
        assign slot      = head_q + PTR_W'(gi);
        assign match[gi] = (CNT_W'(gi) < count_q) && (mem_q[slot] == bus.nextMemoryFloor);
    end
    assign dup_hit = |match;
`else
    assign dup_hit = 1'b0;
`endif

    // A head insert that coincides with a pop reuses the popped slot.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_ok   = 1'b0;
        drop_d  = 1'b0;
        if (bus.wr_valid && !dup_hit) begin
            if (!full_q || pop) begin
                wr_ok = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (pop) begin
            head_d  = head_q + PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
        if (wr_ok) begin
            if (bus.BeginEndMemory_Flag) begin
                if (pop) begin
                    mem_d[head_q] = bus.nextMemoryFloor;
                    head_d        = head_q;
                end else begin
                    head_d        = head_q - PTR_W'(1);
                    mem_d[head_d] = bus.nextMemoryFloor;
                end
            end else begin
                mem_d[tail_q] = bus.nextMemoryFloor;
                tail_d        = tail_q + PTR_W'(1);
            end
            count_d = count_d + CNT_W'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        pos0_d  = empty_d ? '0 : mem_d[head_d];
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pop         = 1'b0;
        timer_start = 1'b0;
        motor_up    = 1'b0;
        motor_down  = 1'b0;
        door_open   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    if (pos0_q == bus.actualFloor) begin
                        pop         = 1'b1;
                        timer_start = 1'b1;
                        state_d     = ST_DOOR;
                    end else begin
                        state_d = ST_MOVE;
                        dir_d   = dir_toward(pos0_q, bus.actualFloor);
                    end
                end
            end
            ST_MOVE: begin
                motor_up   = (dir_q == DIR_UP);
                motor_down = (dir_q == DIR_DOWN);
                if (!empty_q && pos0_q == bus.actualFloor) begin
                    pop         = 1'b1;
                    timer_start = 1'b1;
                    state_d     = ST_DOOR;
                end
            end
            ST_DOOR: begin
                door_open = 1'b1;
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pos0_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pos0_q  <= pos0_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    door_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_door_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .done  (timer_done)
    );

    assign bus.pos0Mem      = pos0_q;
    assign bus.down_up_Flag = dir_q;
    assign bus.motorUp      = motor_up;
    assign bus.motorDown    = motor_down;
    assign bus.doorOpen     = door_open;
    assign bus.queueEmpty   = empty_q;
    assign bus.queueFull    = full_q;
    assign bus.callDropped  = drop_q;

endmodule

// File: tb/tb_floor_call_queue.sv
// Directed bench for floor_call_queue: a queue model predicts stop order, door time and flags.
module tb_floor_call_queue;
    import elevator_pkg::*;

    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    floor_call_queue_if bus ();

    floor_call_queue #(
        .DWELL_CYCLES (DWELL),
        .DEPTH        (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_dup(int f);
        bit hit = 1'b0;
        foreach (sb[i]) hit |= (sb[i] == f);
`ifndef FLOOR_DEDUP_EN
        hit = 1'b0;
`endif
        return hit;
    endfunction

    task automatic check_reset(string tag);
        chk({tag, "_pos0"},  32'(bus.pos0Mem), 32'd0);
        chk({tag, "_dir"},   32'(bus.down_up_Flag), 32'd1);
        chk({tag, "_mup"},   32'(bus.motorUp), 32'd0);
        chk({tag, "_mdn"},   32'(bus.motorDown), 32'd0);
        chk({tag, "_door"},  32'(bus.doorOpen), 32'd0);
        chk({tag, "_empty"}, 32'(bus.queueEmpty), 32'd1);
        chk({tag, "_full"},  32'(bus.queueFull), 32'd0);
        chk({tag, "_drop"},  32'(bus.callDropped), 32'd0);
    endtask

    // Single write strobe; the model decides accept, duplicate or drop.
    task automatic wr(int f, bit head);
        bit exp_drop = 1'b0;
        if (is_dup(f)) begin
        end else if (sb.size() == 4) begin
            exp_drop = 1'b1;
        end else if (head) begin
            sb.push_front(f);
        end else begin
            sb.push_back(f);
        end
        bus.wr_valid            = 1'b1;
        bus.nextMemoryFloor     = 2'(f);
        bus.BeginEndMemory_Flag = head;
        tick();
        bus.wr_valid = 1'b0;
        $display("wr floor=%0d head=%0d queued=%0d", f, head, sb.size());
        chk("wr_drop",  32'(bus.callDropped), 32'(exp_drop));
        chk("wr_full",  32'(bus.queueFull), 32'(sb.size() == 4));
        chk("wr_empty", 32'(bus.queueEmpty), 32'(sb.size() == 0));
        chk("wr_pos0",  32'(bus.pos0Mem), 32'((sb.size() > 0) ? sb[0] : 0));
    endtask

    task automatic drive_to_door();
        for (int i = 0; i < 60 && bus.doorOpen !== 1'b1; i++) begin
            chk("motor_excl", 32'(bus.motorUp & bus.motorDown), 32'd0);
            if (bus.motorUp === 1'b1 && bus.actualFloor != 2'd3)
                bus.actualFloor = bus.actualFloor + 2'd1;
            else if (bus.motorDown === 1'b1 && bus.actualFloor != 2'd0)
                bus.actualFloor = bus.actualFloor - 2'd1;
            tick();
        end
        chk("door_reached", 32'(bus.doorOpen), 32'd1);
    endtask

    task automatic stop_floor();
        int exp = 99;
        if (sb.size() > 0) exp = sb.pop_front();
        $display("stop floor=%0d expected=%0d", bus.actualFloor, exp);
        chk("stop_floor", 32'(bus.actualFloor), 32'(exp));
    endtask

    task automatic door_len();
        int cnt = 0;
        while (bus.doorOpen === 1'b1 && cnt < 300) begin
            cnt++;
            tick();
        end
        chk("door_len", 32'(cnt), 32'(DWELL));
        chk("idle_motors", 32'(bus.motorUp | bus.motorDown), 32'd0);
    endtask

    task automatic serve();
        drive_to_door();
        stop_floor();
        door_len();
    endtask

    initial begin
        int popped;
        int p;
        bus.wr_valid            = 1'b0;
        bus.nextMemoryFloor     = '0;
        bus.BeginEndMemory_Flag = 1'b0;
        bus.actualFloor         = '0;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single call upward from floor 0.
        wr(3, 1'b0);
        tick();
        chk("up_dir", 32'(bus.down_up_Flag), 32'd1);
        chk("up_mup", 32'(bus.motorUp), 32'd1);
        chk("up_mdn", 32'(bus.motorDown), 32'd0);
        serve();
        chk("up_empty", 32'(bus.queueEmpty), 32'd1);

        // Back down to floor 0.
        wr(0, 1'b0);
        tick();
        chk("dn_dir", 32'(bus.down_up_Flag), 32'd0);
        chk("dn_mdn", 32'(bus.motorDown), 32'd1);
        serve();

        // On-the-way head insert while travelling up.
        wr(3, 1'b0);
        tick();
        bus.actualFloor = 2'd1;
        tick();
        wr(2, 1'b1);
        chk("ins_dir", 32'(bus.down_up_Flag), 32'd1);
        chk("ins_mup", 32'(bus.motorUp), 32'd1);
        serve();
        chk("ins_next", 32'(bus.pos0Mem), 32'd3);
        tick();
        chk("ins_resume", 32'(bus.motorUp), 32'd1);
        serve();

        // Duplicate floor handling.
        wr(2, 1'b0);
        wr(2, 1'b0);
        while (sb.size() > 0) serve();
        chk("dup_empty", 32'(bus.queueEmpty), 32'd1);

        // Fill, then overflow.
        wr(1, 1'b0);
        wr(2, 1'b0);
        wr(3, 1'b0);
        wr(0, 1'b0);
        wr(2, 1'b0);
        tick();
        chk("ovf_pulse_end", 32'(bus.callDropped), 32'd0);
        chk("ovf_full", 32'(bus.queueFull), 32'd1);
        chk("ovf_pos0", 32'(bus.pos0Mem), 32'd1);

        // Pop at arrival coinciding with an append while full.
        bus.actualFloor         = 2'd1;
        bus.wr_valid            = 1'b1;
        bus.nextMemoryFloor     = 2'd2;
        bus.BeginEndMemory_Flag = 1'b0;
        tick();
        bus.wr_valid = 1'b0;
        popped = sb.pop_front();
        if (!is_dup(2)) sb.push_back(2);
        $display("wr floor=2 head=0 with pop of %0d queued=%0d", popped, sb.size());
        chk("pw_stop", 32'(bus.actualFloor), 32'(popped));
        chk("pw_door", 32'(bus.doorOpen), 32'd1);
        chk("pw_full", 32'(bus.queueFull), 32'(sb.size() == 4));
        chk("pw_drop", 32'(bus.callDropped), 32'd0);
        chk("pw_pos0", 32'(bus.pos0Mem), 32'(sb[0]));
        door_len();
        while (sb.size() > 0) serve();

        // Reset in the middle of a door dwell with three calls pending.
        p = int'(bus.actualFloor);
        wr(p, 1'b0);
        tick();
        chk("mid_door", 32'(bus.doorOpen), 32'd1);
        stop_floor();
        for (int f = 0; f < 4; f++) begin
            if (f != p) wr(f, 1'b0);
        end
        chk("mid_door_hold", 32'(bus.doorOpen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_empty", 32'(bus.queueEmpty), 32'd1);
        chk("post_rst_door", 32'(bus.doorOpen), 32'd0);
        chk("post_rst_motor", 32'(bus.motorUp | bus.motorDown), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/floor_call_queue.md
FLOOR_CALL_QUEUE -- requirements
Module: floor_call_queue

Interface
REQ-001 Parameter DWELL_CYCLES, default 8: clock cycles doorOpen stays asserted per stop; legal range 1..255.
REQ-002 Parameter DEPTH, default 4: number of queue entries; power of two.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_valid  input  1  one-cycle write strobe for a new floor call.
REQ-006 nextMemoryFloor  input  2  floor number of the call being written.
REQ-007 BeginEndMemory_Flag  input  1  1 = insert at head (on-the-way call), 0 = append at tail.
REQ-008 actualFloor  input  2  current cabin floor from the floor sensors.
REQ-009 pos0Mem  output  2  floor in the head entry; 0 when the queue is empty.
REQ-010 down_up_Flag  output  1  travel direction: 1 = up, 0 = down.
REQ-011 motorUp, motorDown  output  1 each  motor drive; never both 1.
REQ-012 doorOpen  output  1  door-open command.
REQ-013 queueEmpty, queueFull  output  1 each  occupancy status.
REQ-014 callDropped  output  1  one-cycle pulse when a write is discarded.

Function
REQ-015 The queue SHALL store up to DEPTH 2-bit entries in circular head/tail form with a count of width clog2(DEPTH)+1.
REQ-016 A write with BeginEndMemory_Flag=0 SHALL place the floor at the tail; with 1 it SHALL place the floor at the head, ahead of all entries.
REQ-017 A write while full with no pop in the same cycle SHALL be discarded and SHALL pulse callDropped in the next cycle.
REQ-018 The FSM SHALL have states IDLE, MOVE and DOOR.
REQ-019 IDLE: when not empty and pos0Mem == actualFloor -> DOOR with head popped; when not empty and different -> MOVE; when empty, stay.
REQ-020 On IDLE->MOVE, down_up_Flag SHALL be set to (pos0Mem > actualFloor).
REQ-021 MOVE: motorUp = down_up_Flag and motorDown = !down_up_Flag; when actualFloor == pos0Mem -> DOOR, pop head, motors 0 from the next cycle.
REQ-022 DOOR: doorOpen = 1 for exactly DWELL_CYCLES cycles, then -> IDLE.
REQ-023 A pop and a write in the same cycle SHALL both take effect. A head insert SHALL become the new head after the old head is removed. A write while full SHALL be accepted.
REQ-024 A head insert during MOVE SHALL retarget pos0Mem on the next cycle without changing down_up_Flag.
REQ-025 pos0Mem, queueEmpty and queueFull SHALL be registered and reflect the queue one cycle after each write or pop.

Reset
REQ-026 Reset asserted SHALL immediately clear the queue and set the state to IDLE. Output values during reset: pos0Mem=0, down_up_Flag=1, motorUp=motorDown=doorOpen=0, queueEmpty=1, queueFull=0, callDropped=0, dwell counter 0.
REQ-027 Reset during MOVE or DOOR SHALL abandon the stop and discard all pending calls.

Configuration
REQ-028 With FLOOR_DEDUP_EN defined, a write whose floor equals any stored entry SHALL be discarded without a callDropped pulse and without reordering. A head insert of a floor already queued SHALL be dropped likewise.
REQ-029 Without FLOOR_DEDUP_EN, duplicate floors SHALL be stored as separate entries, each causing its own stop.

Structure
REQ-030 A shared package elevator_pkg SHALL hold the floor width constant (2), the FSM state enum and the direction encoding constants.
REQ-031 The dwell counter SHALL be a sub-module door_timer (start, done; DWELL_CYCLES parameter).

Verification
REQ-032 At actualFloor=0, append 3 -> next cycle pos0Mem=3. Then MOVE with down_up_Flag=1 and motorUp=1. When actualFloor=3 -> doorOpen for 8 cycles, then queueEmpty=1 and IDLE.
REQ-033 While moving up to 3 from floor 0, head-insert 2 -> pos0Mem=2. Stop at 2 with 8 door cycles, then pos0Mem=3 and travel resumes up.
REQ-034 Append 1,2,3,0 (full), then a fifth write -> queueFull=1, callDropped pulses once, and the queue content is unchanged.
REQ-035 With the queue full, pop at arrival in the same cycle as an append of 2 -> the write is accepted, the count stays at 4 and callDropped=0.
REQ-036 With FLOOR_DEDUP_EN, append 2 twice -> one entry. Without the macro -> two entries, giving two door cycles at floor 2.
REQ-037 Assert rst_n=0 mid-DOOR with 3 entries queued -> outputs immediately at reset values, queueEmpty=1.
